core_inst_sequencer: RTL

// - Hardware replacement for hand-written stimulus loops. Generates the core's 35-bit inst bus for one full conv layer tile.
// - Per kernel position kij, sequences: weight xmem->L0, L0->PE load, activation xmem->L0, execute, drain, OFIFO->pmem.
// - Then runs the psum accumulation/ReLU pass over pmem. Sits between the host start/done handshake and core.inst.

---
 rtl/core_inst_sequencer_if.sv | 20 ++
 rtl/core_inst_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_inst_sequencer_if.sv
// Host/core signal bundle for core_inst_sequencer: start/done handshake plus the core-facing inst bus.
// Carries the optional hold request when SEQ_HOLD_EN is defined.
interface core_inst_sequencer_if;
  logic        start;
  logic        mode;
  logic        busy;
  logic        done;
  logic        core_rst;
  logic        core_mode;
  logic [34:0] inst;
`ifdef SEQ_HOLD_EN
  logic        hold;

  modport master (output start, mode, hold, input busy, done, core_rst, core_mode, inst);
  modport slave  (input start, mode, hold, output busy, done, core_rst, core_mode, inst);
`else
  modport master (output start, mode, input busy, done, core_rst, core_mode, inst);
  modport slave  (input start, mode, output busy, done, core_rst, core_mode, inst);
`endif
endinterface

// File: rtl/core_inst_sequencer.sv
// Generates the core inst bus for one conv layer tile: per-kij weight/activation/execute/drain/writeback, then psum accumulate + ReLU.
// Define SEQ_HOLD_EN to add a hold input that freezes the sequence and idles the bus.
//
// state      | meaning
// S_IDLE     | waiting for start
// S_RST      | core_rst pulse before each kij
// S_W_L0     | weight xmem reads, l0_wr one cycle behind
// S_W_LOAD   | L0 -> PE weight load
// S_GAP      | idle after weight load
// S_A_L0     | activation xmem reads, l0_wr one cycle behind
// S_EXEC     | execute from L0
// S_DRAIN    | idle while the array drains
// S_OFIFO    | ofifo_rd, pmem write one cycle behind
// S_ACC_RST  | core_rst before each output accumulation
// S_ACC_RD   | KK pmem reads, acc one cycle behind
// S_ACC_RELU | relu for the current output
// S_DONE     | done pulse
module core_inst_sequencer #(
  parameter int KSIZE    = 3,
  parameter int A_DIM    = 6,
  parameter int COL      = 8,
  parameter int W_BASE   = 1024,
  parameter int W_STRIDE = 16,
  parameter int RST_CYC  = 10,
  parameter int GAP_CYC  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  core_inst_sequencer_if.slave  bus
);
  localparam int KK    = KSIZE * KSIZE;
  localparam int NIJ   = A_DIM * A_DIM;
  localparam int O_DIM = A_DIM - KSIZE + 1;
  localparam int NONIJ = O_DIM * O_DIM;
  localparam int AW    = 11;
  localparam int M1    = (RST_CYC > GAP_CYC) ? RST_CYC : GAP_CYC;
  localparam int M2    = (NIJ + 1 > 2 * COL + 1) ? NIJ + 1 : 2 * COL + 1;
  localparam int M3    = (M1 > M2) ? M1 : M2;
  localparam int CMAX  = (M3 > KK + 1) ? M3 : KK + 1;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int KW    = $clog2(KK + 1);
  localparam int OW    = $clog2(NONIJ + 1);

  localparam int B_RELU     = 34;
  localparam int B_ACC      = 33;
  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int B_AP_LO    = 20;
  localparam int B_CEN_X    = 19;
  localparam int B_AX_LO    = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  localparam logic [34:0] INST_IDLE = 35'h1_800C_0000;

  typedef enum logic [3:0] {
    S_IDLE, S_RST, S_W_L0, S_W_LOAD, S_GAP, S_A_L0, S_EXEC,
    S_DRAIN, S_OFIFO, S_ACC_RST, S_ACC_RD, S_ACC_RELU, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [KW-1:0]   kij_q, kij_d;
  logic [OW-1:0]   o_q, o_d;
  logic            mode_q, mode_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            core_rst_q, core_rst_d;
  logic [34:0]     inst_q, inst_d;

  logic [CW-1:0]   n_words;
  logic [CW-1:0]   last_cnt;
  logic            cnt_last;
  logic            hold_act;
  logic [AW-1:0]   w_addr;
  logic [AW-1:0]   p_waddr;
  logic [AW-1:0]   p_raddr;

`ifdef SEQ_HOLD_EN
  // DONE is never frozen so the done pulse stays exactly one cycle
  assign hold_act = bus.hold && (state_q != S_IDLE) && (state_q != S_DONE);
`else
  assign hold_act = 1'b0;
`endif

  assign n_words = mode_q ? CW'(2 * COL) : CW'(COL);
  assign w_addr  = AW'(W_BASE + 32'(kij_q) * W_STRIDE + 32'(cnt_q));
  assign p_waddr = AW'(32'(kij_q) * NIJ + 32'(cnt_q) - 1);
  assign p_raddr = AW'((32'(o_q) / O_DIM) * A_DIM + 32'(o_q) % O_DIM
                       + (32'(cnt_q) / KSIZE) * A_DIM + 32'(cnt_q) % KSIZE
                       + 32'(cnt_q) * NIJ);

  always_comb begin
    last_cnt = '0;
    case (state_q)
      S_RST:            last_cnt = CW'(RST_CYC - 1);
      S_W_L0:           last_cnt = n_words;
      S_W_LOAD:         last_cnt = n_words - CW'(1);
      S_GAP:            last_cnt = CW'(GAP_CYC - 1);
      S_A_L0, S_OFIFO:  last_cnt = CW'(NIJ);
      S_EXEC, S_DRAIN:  last_cnt = CW'(NIJ - 1);
      S_ACC_RD:         last_cnt = CW'(KK);
      default:          last_cnt = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    kij_d    = kij_q;
    o_d      = o_q;
    mode_d   = mode_q;
    cnt_last = (cnt_q == last_cnt);
    if (state_q == S_IDLE) begin
      if (bus.start) begin
        state_d = S_RST;
        cnt_d   = '0;
        kij_d   = '0;
        o_d     = '0;
        mode_d  = bus.mode;
      end
    end else if (!hold_act) begin
      if (!cnt_last) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = '0;
        case (state_q)
          S_RST:      state_d = S_W_L0;
          S_W_L0:     state_d = S_W_LOAD;
          S_W_LOAD:   state_d = S_GAP;
          S_GAP:      state_d = S_A_L0;
          S_A_L0:     state_d = S_EXEC;
          S_EXEC:     state_d = S_DRAIN;
          S_DRAIN:    state_d = S_OFIFO;
          S_OFIFO: begin
            if (kij_q == KW'(KK - 1)) begin
              state_d = S_ACC_RST;
            end else begin
              state_d = S_RST;
              kij_d   = kij_q + KW'(1);
            end
          end
          S_ACC_RST:  state_d = S_ACC_RD;
          S_ACC_RD:   state_d = S_ACC_RELU;
          S_ACC_RELU: begin
            if (o_q == OW'(NONIJ - 1)) begin
              state_d = S_DONE;
            end else begin
              state_d = S_ACC_RST;
              o_d     = o_q + OW'(1);
            end
          end
          default:    state_d = S_IDLE;
        endcase
      end
    end
  end

  // Consumers (l0_wr, pmem write, acc) trail their read by one counter step
  always_comb begin
    inst_d     = INST_IDLE;
    core_rst_d = 1'b0;
    if (!hold_act) begin
      case (state_q)
        S_RST, S_ACC_RST: core_rst_d = 1'b1;
        S_W_L0: begin
          if (cnt_q < n_words) begin
            inst_d[B_CEN_X]         = 1'b0;
            inst_d[B_AX_LO +: AW]   = w_addr;
          end
          inst_d[B_L0_WR] = (cnt_q != '0);
        end
        S_W_LOAD: begin
          inst_d[B_L0_RD] = 1'b1;
          inst_d[B_LOAD]  = 1'b1;
        end
        S_A_L0: begin
          if (cnt_q < CW'(NIJ)) begin
            inst_d[B_CEN_X]         = 1'b0;
            inst_d[B_AX_LO +: AW]   = AW'(cnt_q);
          end
          inst_d[B_L0_WR] = (cnt_q != '0);
        end
        S_EXEC: begin
          inst_d[B_L0_RD] = 1'b1;
          inst_d[B_EXEC]  = 1'b1;
        end
        S_OFIFO: begin
          inst_d[B_OFIFO_RD] = (cnt_q < CW'(NIJ));
          if (cnt_q != '0) begin
            inst_d[B_CEN_P]       = 1'b0;
            inst_d[B_WEN_P]       = 1'b0;
            inst_d[B_AP_LO +: AW] = p_waddr;
          end
        end
        S_ACC_RD: begin
          if (cnt_q < CW'(KK)) begin
            inst_d[B_CEN_P]       = 1'b0;
            inst_d[B_AP_LO +: AW] = p_raddr;
          end
          inst_d[B_ACC] = (cnt_q != '0);
        end
        S_ACC_RELU: inst_d[B_RELU] = 1'b1;
        default: ;
      endcase
    end
  end

  assign busy_d = (state_d != S_IDLE);
  assign done_d = (state_d == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      kij_q      <= '0;
      o_q        <= '0;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      core_rst_q <= 1'b1;
      inst_q     <= INST_IDLE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      kij_q      <= kij_d;
      o_q        <= o_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      core_rst_q <= core_rst_d;
      inst_q     <= inst_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.core_rst  = core_rst_q;
  assign bus.core_mode = mode_q;
  assign bus.inst      = inst_q;
endmodule
